// File: rtl/gvizi_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gvizi_cfg_pkg
// Purpose  : Shared register map, host frame layout and sequencer state
//            encoding for the GVI/GZI delay-generator configuration path.
// Revision : 1.0 - initial release
// ============================================================================
package gvizi_cfg_pkg;

  // Register bank map
  localparam logic [3:0] ADDR_VERSION = 4'd0;
  localparam logic [3:0] ADDR_CH_EN   = 4'd1;
  localparam logic [3:0] ADDR_MODE    = 4'd2;
  localparam logic [3:0] ADDR_CNT0    = 4'd3;
  localparam logic [3:0] ADDR_DAC0    = 4'd4;
  localparam logic [3:0] ADDR_CNT1    = 4'd5;
  localparam logic [3:0] ADDR_DAC1    = 4'd6;
  localparam logic [3:0] ADDR_CNT2    = 4'd7;
  localparam logic [3:0] ADDR_DAC2    = 4'd8;
  localparam logic [3:0] ADDR_CNT3    = 4'd9;
  localparam logic [3:0] ADDR_DAC3    = 4'd10;
  localparam logic [3:0] ADDR_PRESC   = 4'd11;

  // Host frame field positions
  localparam int FRAME_RW_BIT  = 23;
  localparam int FRAME_RSV_HI  = 22;
  localparam int FRAME_RSV_LO  = 20;
  localparam int FRAME_ADDR_HI = 19;
  localparam int FRAME_ADDR_LO = 16;
  localparam int FRAME_DATA_HI = 15;
  localparam int FRAME_DATA_LO = 0;

  // Queued entry is {address, data}
  localparam int ENTRY_W = 20;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    DRAIN     = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cfg_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cfg_fifo
// Purpose  : Synchronous FIFO holding accepted {address, data} entries.
//            Read data is registered on pop (no fall-through) and holds its
//            value between pops.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_fifo
  import gvizi_cfg_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage array; no reset needed since only occupied slots are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and the registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/cfg_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cfg_write_sequencer
// Purpose  : Validates host configuration frames, queues them, and writes
//            them into the register bank as one atomic batch inside the
//            pulse generator's safe update window.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_write_sequencer
  import gvizi_cfg_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int ADDR_MAX = 11
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_spi_done,
  input  logic [23:0]             i_frame,
  input  logic                    i_cycle_end,
  output logic                    o_wr_en,
  output logic [3:0]              o_wr_addr,
  output logic [15:0]             o_wr_data,
  output logic                    o_commit,
  output logic                    o_busy,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_overflow,
  output logic [7:0]              o_err_cnt
);

  localparam int         LW         = $clog2(DEPTH) + 1;
  localparam logic [3:0] ADDR_MAX_L = 4'(ADDR_MAX);

  state_t          state;
  state_t          state_next;
  logic [LW-1:0]   batch;
  logic [LW-1:0]   batch_next;
  logic            pop;
  logic            commit_next;

  logic [3:0]      addr;
  logic [2:0]      rsv;
  logic [15:0]     data;
  logic            addr_zero;
  logic            fmt_ok;
  logic            push;
  logic            reject_err;
  logic            reject_full;
  logic            fifo_full;
  logic            fifo_empty;
  logic [ENTRY_W-1:0] rd_entry;
  logic            unused_rw;

  assign addr      = i_frame[FRAME_ADDR_HI:FRAME_ADDR_LO];
  assign rsv       = i_frame[FRAME_RSV_HI:FRAME_RSV_LO];
  assign data      = i_frame[FRAME_DATA_HI:FRAME_DATA_LO];
  assign unused_rw = i_frame[FRAME_RW_BIT];

  // Address 0 is the read-only version register: dropped without counting.
  assign addr_zero   = (addr == ADDR_VERSION);
  assign fmt_ok      = (rsv == 3'b000) && (addr <= ADDR_MAX_L);
  assign push        = i_spi_done && !addr_zero && fmt_ok && !fifo_full;
  assign reject_err  = i_spi_done && !addr_zero && !(fmt_ok && !fifo_full);
  assign reject_full = i_spi_done && !addr_zero && fmt_ok && fifo_full;

  cfg_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .push    (push),
    .wr_data ({addr, data}),
    .pop     (pop),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (o_level)
  );

  // The registered FIFO read port is the bank address/data bus, so it holds
  // its last value whenever no write is in progress.
  assign o_wr_addr = rd_entry[ENTRY_W-1:16];
  assign o_wr_data = rd_entry[15:0];

  // State and batch counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      batch <= '0;
    end else begin
      state <= state_next;
      batch <= batch_next;
    end
  end

  // Next state, pop request and commit; batch counts pops still owed.
  always_comb begin
    state_next  = state;
    batch_next  = batch;
    pop         = 1'b0;
    commit_next = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) state_next = WAIT_SYNC;
      end
      WAIT_SYNC: begin
        // Batch size uses the pre-edge level, so a same-cycle push waits.
        if (i_cycle_end && !fifo_empty) begin
          pop        = 1'b1;
          batch_next = o_level - LW'(1);
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (batch != '0) begin
          pop        = 1'b1;
          batch_next = batch - LW'(1);
        end else begin
          commit_next = 1'b1;
          state_next  = fifo_empty ? IDLE : WAIT_SYNC;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered strobes, busy flag and error bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wr_en    <= 1'b0;
      o_commit   <= 1'b0;
      o_busy     <= 1'b0;
      o_overflow <= 1'b0;
      o_err_cnt  <= 8'd0;
    end else begin
      o_wr_en  <= pop;
      o_commit <= commit_next;
      o_busy   <= !fifo_empty || (state != IDLE);
      if (reject_full) o_overflow <= 1'b1;
      if (reject_err && (o_err_cnt != 8'hFF)) o_err_cnt <= o_err_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cfg_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfg_write_sequencer
// Purpose  : Directed-vector bench with a write scoreboard for
//            cfg_write_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfg_write_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_done = 1'b0;
  logic [23:0] frame = 24'd0;
  logic        cycle_end = 1'b0;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        commit;
  logic        busy;
  logic [3:0]  level;
  logic        overflow;
  logic [7:0]  err_cnt;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  int commit_count = 0;
  logic prev_wr_en = 1'b0;
  logic [19:0] exp_q [$];

  cfg_write_sequencer #(.DEPTH(8), .ADDR_MAX(11)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_spi_done  (spi_done),
    .i_frame     (frame),
    .i_cycle_end (cycle_end),
    .o_wr_en     (wr_en),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_commit    (commit),
    .o_busy      (busy),
    .o_level     (level),
    .o_overflow  (overflow),
    .o_err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: every bank write is popped from the scoreboard and compared;
  // a commit must immediately follow the last write of a batch.
  always @(negedge clk) begin
    if (wr_en) begin
      logic [19:0] e;
      wr_count++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, none expected", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          fails++;
          $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   wr_addr, wr_data, e[19:16], e[15:0]);
        end
      end
    end
    if (commit) begin
      commit_count++;
      tests++;
      if (!prev_wr_en || wr_en) begin
        fails++;
        $display("FAIL commit_timing: prev_wr_en=%b wr_en=%b, expected 1/0", prev_wr_en, wr_en);
      end
    end
    prev_wr_en = wr_en;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; an accepted frame's write is queued as expected.
  task automatic drive(input logic [23:0] f, input logic sd, input logic ce, input logic accept);
    spi_done  = sd;
    frame     = f;
    cycle_end = ce;
    if (accept) exp_q.push_back(f[19:0]);
    tick(1);
    spi_done  = 1'b0;
    cycle_end = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    exp_q.delete();
    rst = 1'b0;
    tick(1);
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy && !wr_en && level == 0 && exp_q.size() == 0) begin
        done = 1;
        break;
      end
      tick(1);
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int w0;
    int c0;

    // Reset values
    tick(3);
    chk("rst_wr_en",    {31'd0, wr_en}, 0);
    chk("rst_addr",     {28'd0, wr_addr}, 0);
    chk("rst_data",     {16'd0, wr_data}, 0);
    chk("rst_commit",   {31'd0, commit}, 0);
    chk("rst_busy",     {31'd0, busy}, 0);
    chk("rst_level",    {28'd0, level}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    chk("rst_err_cnt",  {24'd0, err_cnt}, 0);
    rst = 1'b0;
    tick(1);

    // Basic two-frame batch with exact cycle timing
    drive(24'h030100, 1, 0, 1);
    drive(24'h0400A5, 1, 0, 1);
    chk("t1_level2", {28'd0, level}, 2);
    tick(2);
    drive(24'h0, 0, 1, 0);
    chk("t1_w1_en",   {31'd0, wr_en}, 1);
    chk("t1_w1",      {12'd0, wr_addr, wr_data}, 32'h30100);
    tick(1);
    chk("t1_w2_en",   {31'd0, wr_en}, 1);
    chk("t1_w2",      {12'd0, wr_addr, wr_data}, 32'h400A5);
    tick(1);
    chk("t1_commit",  {31'd0, commit}, 1);
    chk("t1_wr_off",  {31'd0, wr_en}, 0);
    chk("t1_hold",    {12'd0, wr_addr, wr_data}, 32'h400A5);
    tick(1);
    chk("t1_commit_1cyc", {31'd0, commit}, 0);
    chk("t1_level0",  {28'd0, level}, 0);
    wait_idle("t1_idle");

    // Rejected frames: bad address, reserved bits set, silent address 0
    w0 = wr_count;
    drive(24'h0C1234, 1, 0, 0);
    drive(24'h551111, 1, 0, 0);
    drive(24'h002222, 1, 0, 0);
    tick(3);
    chk("t2_err_cnt", {24'd0, err_cnt}, 2);
    chk("t2_level",   {28'd0, level}, 0);
    chk("t2_busy",    {31'd0, busy}, 0);
    chk("t2_no_wr",   wr_count - w0, 0);

    // Overflow: ninth frame into a full 8-deep FIFO
    do_reset();
    for (int i = 1; i <= 9; i++)
      drive({8'h0, 4'(i), 4'h0, 12'(i * 12'h111)}, 1, 0, (i <= 8));
    chk("t3_overflow", {31'd0, overflow}, 1);
    chk("t3_err_cnt",  {24'd0, err_cnt}, 1);
    chk("t3_level8",   {28'd0, level}, 8);
    w0 = wr_count;
    tick(2);
    drive(24'h0, 0, 1, 0);
    wait_idle("t3_idle");
    chk("t3_writes",   wr_count - w0, 8);

    // Frame pushed during DRAIN waits for the next window
    do_reset();
    w0 = wr_count;
    c0 = commit_count;
    drive(24'h02ABCD, 1, 0, 1);
    drive(24'h031234, 1, 0, 1);
    tick(2);
    drive(24'h0, 0, 1, 0);
    drive(24'h055555, 1, 0, 1);
    tick(1);
    chk("t4_commit", {31'd0, commit}, 1);
    tick(5);
    chk("t4_level1",  {28'd0, level}, 1);
    chk("t4_busy",    {31'd0, busy}, 1);
    chk("t4_writes2", wr_count - w0, 2);
    chk("t4_commits", commit_count - c0, 1);
    drive(24'h0, 0, 1, 0);
    wait_idle("t4_idle");
    chk("t4_writes3", wr_count - w0, 3);

    // Push coinciding with the sync strobe is excluded from the batch
    do_reset();
    w0 = wr_count;
    drive(24'h061111, 1, 0, 1);
    tick(2);
    drive(24'h072222, 1, 1, 1);
    chk("t5_level", {28'd0, level}, 1);
    tick(4);
    chk("t5_one_wr", wr_count - w0, 1);
    chk("t5_level_wait", {28'd0, level}, 1);
    drive(24'h0, 0, 1, 0);
    wait_idle("t5_idle");
    chk("t5_two_wr", wr_count - w0, 2);

    // Reset during the second write of a four-frame batch
    do_reset();
    for (int i = 0; i < 4; i++)
      drive({8'h0, 4'(i + 3), 12'h0, 4'(i)}, 1, 0, 1);
    tick(2);
    drive(24'h0, 0, 1, 0);
    tick(1);
    chk("t6_w2_en", {31'd0, wr_en}, 1);
    rst = 1'b1;
    tick(1);
    exp_q.delete();
    chk("t6_outs_zero", {wr_en, wr_addr, wr_data, commit, busy, level, overflow, err_cnt}, 0);
    rst = 1'b0;
    w0 = wr_count;
    tick(10);
    chk("t6_no_wr", wr_count - w0, 0);
    chk("t6_level", {28'd0, level}, 0);
    chk("t6_busy",  {31'd0, busy}, 0);

    // Error counter saturation
    do_reset();
    for (int i = 0; i < 254; i++) drive(24'h0F0000, 1, 0, 0);
    chk("t7_err_254", {24'd0, err_cnt}, 254);
    for (int i = 0; i < 6; i++) drive(24'h0F0000, 1, 0, 0);
    tick(1);
    chk("t7_err_sat", {24'd0, err_cnt}, 255);
    chk("t7_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
